yacc_access_sequencer: RTL and testbench

- Sequences one access at a time through the 8-set, 8-way YACC compressed cache datapath: tag lookup, memory fetch on miss, compression-factor (CF) classification, way allocation and fill.
- Owns the per-set LRU order state and chooses the victim inside the CF way region when the datapath offers no merge or empty candidate.
- Sits between the upstream requester and the cache tag/data arrays plus the backing memory port.

---
 rtl/yacc_pkg.sv | 81 ++++++++
 rtl/yacc_lru_order.sv | 82 ++++++++
 rtl/yacc_access_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_yacc_access_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yacc_pkg.sv
// yacc_pkg: shared types and constants for the YACC access sequencer.
//
// Contents:
//   cf_t         compression-factor classes and the way region each one owns
//   state_t      sequencer FSM states
//   address field bit positions (tag 31:11, index 10:8, block 7:6, offset 5:0)
//   LINE_W       uncompressed line width in bits
//   classify_cf  picks the CF class from the zero-ness of the upper line bits
//   in_region    tests whether a way belongs to the region of a CF class
package yacc_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 512;
  localparam int SETS     = 8;
  localparam int WAYS     = 8;
  localparam int SET_W    = 3;
  localparam int WAY_W    = 3;
  localparam int CF_W     = 2;
  localparam int OFFSET_W = 6;

  localparam int BLOCK_LSB = 6;
  localparam int BLOCK_MSB = 7;
  localparam int INDEX_LSB = 8;
  localparam int INDEX_MSB = 10;
  localparam int TAG_LSB   = 11;
  localparam int TAG_MSB   = 31;
  localparam int TAG_W     = TAG_MSB - TAG_LSB + 1;
  localparam int BLOCK_W   = BLOCK_MSB - BLOCK_LSB + 1;

  // Clears the byte offset so memory always sees a line-aligned address.
  localparam logic [ADDR_W-1:0] LINE_ADDR_MASK =
    {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  typedef enum logic [CF_W-1:0] {
    CF_NONE    = 2'b00,
    CF_HALF    = 2'b01,
    CF_QUARTER = 2'b10
  } cf_t;

  localparam logic [WAY_W-1:0] CF_NONE_MIN_WAY    = 3'd0;
  localparam logic [WAY_W-1:0] CF_NONE_MAX_WAY    = 3'd3;
  localparam logic [WAY_W-1:0] CF_HALF_MIN_WAY    = 3'd4;
  localparam logic [WAY_W-1:0] CF_HALF_MAX_WAY    = 3'd5;
  localparam logic [WAY_W-1:0] CF_QUARTER_MIN_WAY = 3'd6;
  localparam logic [WAY_W-1:0] CF_QUARTER_MAX_WAY = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM,
    S_ALLOC,
    S_FILL,
    S_RESP
  } state_t;

  // A line whose upper three quarters are zero fits four to a way; one whose
  // upper half is zero fits two to a way. The all-zero line lands in QUARTER.
  function automatic cf_t classify_cf(input logic [LINE_W-1:0] line);
    cf_t cf;
    if (line[LINE_W-1:LINE_W/4] == '0) begin
      cf = CF_QUARTER;
    end else if (line[LINE_W-1:LINE_W/2] == '0) begin
      cf = CF_HALF;
    end else begin
      cf = CF_NONE;
    end
    return cf;
  endfunction

  // The unused encoding 2'b11 is treated as uncompressed.
  function automatic logic in_region(input cf_t cf, input logic [WAY_W-1:0] way);
    logic hit;
    case (cf)
      CF_HALF:    hit = (way >= CF_HALF_MIN_WAY) && (way <= CF_HALF_MAX_WAY);
      CF_QUARTER: hit = (way >= CF_QUARTER_MIN_WAY) && (way <= CF_QUARTER_MAX_WAY);
      default:    hit = (way >= CF_NONE_MIN_WAY) && (way <= CF_NONE_MAX_WAY);
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/yacc_lru_order.sv
// yacc_lru_order: per-set recency order of the eight ways.
//
// Each set keeps an ordered list; position 0 holds the most recently used
// way and position 7 the least recently used one. Reset puts way p at
// position p in every set.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   touch_valid    move touch_way of set touch_index to position 0
//   touch_index    set to update
//   touch_way      way being used
//   pick_index     set to choose a victim from (combinational)
//   pick_cf        CF class whose way region limits the choice
//   pick_way       least recent way inside that region
module yacc_lru_order
  import yacc_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             touch_valid,
  input  logic [SET_W-1:0] touch_index,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [SET_W-1:0] pick_index,
  input  cf_t              pick_cf,
  output logic [WAY_W-1:0] pick_way
);

  typedef logic [WAYS-1:0][WAY_W-1:0] row_t;

  row_t             order_q [SETS];
  row_t             touch_row;
  row_t             touched_row;
  row_t             pick_row;
  logic [WAY_W-1:0] touch_pos;
  logic             pick_found;

  // Entries ahead of the touched way slide back one place; entries behind it
  // keep their place. Touching position 0 therefore changes nothing.
  always_comb begin
    touch_row = order_q[touch_index];
    touch_pos = '0;
    for (int p = 0; p < WAYS; p++) begin
      if (touch_row[p] == touch_way) begin
        touch_pos = WAY_W'(p);
      end
    end
    touched_row    = touch_row;
    touched_row[0] = touch_way;
    for (int p = 1; p < WAYS; p++) begin
      if (WAY_W'(p) <= touch_pos) begin
        touched_row[p] = touch_row[p-1];
      end
    end
  end

  // Every region holds at least one way and each row is a permutation, so
  // the scan from the oldest position always finds a candidate.
  always_comb begin
    pick_row   = order_q[pick_index];
    pick_way   = '0;
    pick_found = 1'b0;
    for (int p = WAYS - 1; p >= 0; p--) begin
      if (!pick_found && in_region(pick_cf, pick_row[p])) begin
        pick_way   = pick_row[p];
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int p = 0; p < WAYS; p++) begin
          order_q[s][p] <= WAY_W'(p);
        end
      end
    end else if (touch_valid) begin
      order_q[touch_index] <= touched_row;
    end
  end

endmodule

// File: rtl/yacc_access_sequencer.sv
// yacc_access_sequencer: runs one access at a time through the YACC
// compressed cache: tag lookup, memory fetch on miss, CF classification,
// way allocation, fill and response. Owns the per-set LRU order.
//
// Optional feature macro: YACC_STATS_EN
//   defined   -> hit_count / miss_count are 32-bit saturating counters,
//                bumped on each response handshake
//   undefined -> both outputs are tied to zero and no counter is built
//
// Ports:
//   clock, reset                        clock, async active-high reset
//   req_valid/req_ready/req_addr        upstream request (accepted in IDLE)
//   lk_valid/lk_tag/lk_index/lk_block   lookup strobe and address fields
//   lk_done/lk_hit/lk_way/lk_data       lookup result
//   mem_req/mem_addr/mem_ack/mem_data   line fetch from backing memory
//   alloc_valid/alloc_cf                allocation query for a CF class
//   alloc_done/alloc_cand_*             datapath merge/empty candidate
//   fill_valid/fill_way/fill_cf/
//   fill_merge/fill_data/fill_ack       fill command to the arrays
//   rsp_valid/rsp_ready/rsp_hit/rsp_data response to the requester
//   hit_count/miss_count                optional statistics
module yacc_access_sequencer
  import yacc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,

  output logic              lk_valid,
  output logic [TAG_W-1:0]  lk_tag,
  output logic [SET_W-1:0]  lk_index,
  output logic [BLOCK_W-1:0] lk_block,
  input  logic              lk_done,
  input  logic              lk_hit,
  input  logic [WAY_W-1:0]  lk_way,
  input  logic [LINE_W-1:0] lk_data,

  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_data,

  output logic              alloc_valid,
  output logic [CF_W-1:0]   alloc_cf,
  input  logic              alloc_done,
  input  logic              alloc_cand_valid,
  input  logic [WAY_W-1:0]  alloc_cand_way,
  input  logic              alloc_cand_merge,

  output logic              fill_valid,
  output logic [WAY_W-1:0]  fill_way,
  output logic [CF_W-1:0]   fill_cf,
  output logic              fill_merge,
  output logic [LINE_W-1:0] fill_data,
  input  logic              fill_ack,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [LINE_W-1:0] rsp_data,

  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  state_t            state_q;
  state_t            state_d;
  logic              entry_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  cf_t               cf_q;
  logic [WAY_W-1:0]  fill_way_q;
  logic              fill_merge_q;
  logic              rsp_hit_q;

  logic              touch_valid;
  logic [WAY_W-1:0]  touch_way;
  logic [WAY_W-1:0]  pick_way;
  logic              rsp_fire;

  yacc_lru_order u_lru (
    .clock       (clock),
    .reset       (reset),
    .touch_valid (touch_valid),
    .touch_index (addr_q[INDEX_MSB:INDEX_LSB]),
    .touch_way   (touch_way),
    .pick_index  (addr_q[INDEX_MSB:INDEX_LSB]),
    .pick_cf     (cf_q),
    .pick_way    (pick_way)
  );

  // Next state plus the LRU touch: a hit touches the hit way, a completed
  // fill touches the way it was written into.
  always_comb begin
    state_d     = state_q;
    touch_valid = 1'b0;
    touch_way   = lk_way;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (lk_done) begin
          if (lk_hit) begin
            touch_valid = 1'b1;
            state_d     = S_RESP;
          end else begin
            state_d = S_MEM;
          end
        end
      end
      S_MEM: begin
        if (mem_ack) state_d = S_ALLOC;
      end
      S_ALLOC: begin
        if (alloc_done) state_d = S_FILL;
      end
      S_FILL: begin
        touch_way = fill_way_q;
        if (fill_ack) begin
          touch_valid = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // entry_q marks the first cycle spent in a state, which is when the
  // one-shot lookup and allocation strobes fire. One line register serves
  // both hit data and fetched data, so rsp_data and fill_data share it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      entry_q      <= 1'b0;
      addr_q       <= '0;
      line_q       <= '0;
      cf_q         <= CF_NONE;
      fill_way_q   <= '0;
      fill_merge_q <= 1'b0;
      rsp_hit_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      case (state_q)
        S_IDLE: begin
          if (req_valid) addr_q <= req_addr;
        end
        S_LOOKUP: begin
          if (lk_done) begin
            rsp_hit_q <= lk_hit;
            if (lk_hit) line_q <= lk_data;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            line_q <= mem_data;
            cf_q   <= classify_cf(mem_data);
          end
        end
        S_ALLOC: begin
          if (alloc_done) begin
            fill_way_q   <= alloc_cand_valid ? alloc_cand_way : pick_way;
            fill_merge_q <= alloc_cand_valid & alloc_cand_merge;
          end
        end
        S_FILL: begin
          if (fill_ack) rsp_hit_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // req_ready is also masked by reset so every output reads zero while
  // reset is held.
  assign req_ready   = (state_q == S_IDLE) && !reset;
  assign lk_valid    = (state_q == S_LOOKUP) && entry_q;
  assign lk_tag      = addr_q[TAG_MSB:TAG_LSB];
  assign lk_index    = addr_q[INDEX_MSB:INDEX_LSB];
  assign lk_block    = addr_q[BLOCK_MSB:BLOCK_LSB];
  assign mem_req     = (state_q == S_MEM);
  assign mem_addr    = addr_q & LINE_ADDR_MASK;
  assign alloc_valid = (state_q == S_ALLOC) && entry_q;
  assign alloc_cf    = cf_q;
  assign fill_valid  = (state_q == S_FILL);
  assign fill_way    = fill_way_q;
  assign fill_cf     = cf_q;
  assign fill_merge  = fill_merge_q;
  assign fill_data   = line_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_hit     = rsp_hit_q;
  assign rsp_data    = line_q;
  assign rsp_fire    = (state_q == S_RESP) && rsp_ready;

`ifdef YACC_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (rsp_fire) begin
      if (rsp_hit_q) begin
        if (hit_q != '1) hit_q <= hit_q + 32'd1;
      end else begin
        if (miss_q != '1) miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
  assign hit_count   = '0;
  assign miss_count  = '0;
`endif

endmodule

// File: tb/tb_yacc_access_sequencer.sv
// tb_yacc_access_sequencer: directed self-checking bench for
// yacc_access_sequencer. Expected values are worked out by hand from the
// address layout, the CF thresholds and the LRU order rules.
module tb_yacc_access_sequencer;

  logic         clock;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         lk_valid;
  logic [20:0]  lk_tag;
  logic [2:0]   lk_index;
  logic [1:0]   lk_block;
  logic         lk_done;
  logic         lk_hit;
  logic [2:0]   lk_way;
  logic [511:0] lk_data;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [511:0] mem_data;
  logic         alloc_valid;
  logic [1:0]   alloc_cf;
  logic         alloc_done;
  logic         alloc_cand_valid;
  logic [2:0]   alloc_cand_way;
  logic         alloc_cand_merge;
  logic         fill_valid;
  logic [2:0]   fill_way;
  logic [1:0]   fill_cf;
  logic         fill_merge;
  logic [511:0] fill_data;
  logic         fill_ack;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_hit;
  logic [511:0] rsp_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int tests_run;
  int tests_failed;

  // Identity order packed with position 7 in the top digit.
  localparam logic [23:0] ORDER_IDENTITY = 24'o76543210;

  localparam logic [511:0] LINE_HIT_A  = {8{64'h0123_4567_89AB_CDEF}};
  localparam logic [511:0] LINE_QUART  = {384'b0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555};
  localparam logic [511:0] LINE_HALF   = {256'b0, 64'h0000_0000_0000_0100, 192'h1};
  localparam logic [511:0] LINE_FULL   = {8{64'hA5A5_0000_1234_5678}};
  localparam logic [511:0] LINE_HIT_B  = {16{32'hCAFE_F00D}};

  yacc_access_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .lk_valid         (lk_valid),
    .lk_tag           (lk_tag),
    .lk_index         (lk_index),
    .lk_block         (lk_block),
    .lk_done          (lk_done),
    .lk_hit           (lk_hit),
    .lk_way           (lk_way),
    .lk_data          (lk_data),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_data         (mem_data),
    .alloc_valid      (alloc_valid),
    .alloc_cf         (alloc_cf),
    .alloc_done       (alloc_done),
    .alloc_cand_valid (alloc_cand_valid),
    .alloc_cand_way   (alloc_cand_way),
    .alloc_cand_merge (alloc_cand_merge),
    .fill_valid       (fill_valid),
    .fill_way         (fill_way),
    .fill_cf          (fill_cf),
    .fill_merge       (fill_merge),
    .fill_data        (fill_data),
    .fill_ack         (fill_ack),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_hit          (rsp_hit),
    .rsp_data         (rsp_data),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents a request together with the lookup answer and the memory line.
  task automatic applyStimulus(input logic [31:0] addr, input logic hit,
                               input logic [2:0] way, input logic [511:0] line);
    req_valid = 1'b1;
    req_addr  = addr;
    lk_done   = 1'b1;
    lk_hit    = hit;
    lk_way    = way;
    lk_data   = line;
    mem_data  = line;
  endtask

  // Full access with every handshake answering at once.
  task automatic runTransaction(input logic [31:0] addr, input logic hit,
                                input logic [2:0] way, input logic [511:0] line);
    int n;
    applyStimulus(addr, hit, way, line);
    mem_ack          = 1'b1;
    alloc_done       = 1'b1;
    alloc_cand_valid = 1'b0;
    alloc_cand_merge = 1'b0;
    fill_ack         = 1'b1;
    rsp_ready        = 1'b0;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("txn_rsp_seen", 512'(rsp_valid), 512'(1));
    checkOutput("txn_latency", 512'(n), hit ? 512'(1) : 512'(4));
    checkOutput("txn_rsp_hit", 512'(rsp_hit), 512'(hit));
    checkOutput("txn_rsp_data", rsp_data, line);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    req_valid        = 1'b0;
    req_addr         = '0;
    lk_done          = 1'b0;
    lk_hit           = 1'b0;
    lk_way           = '0;
    lk_data          = '0;
    mem_ack          = 1'b0;
    mem_data         = '0;
    alloc_done       = 1'b0;
    alloc_cand_valid = 1'b0;
    alloc_cand_way   = '0;
    alloc_cand_merge = 1'b0;
    fill_ack         = 1'b0;
    rsp_ready        = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_req_ready", 512'(req_ready), 512'(0));
    checkOutput("rst_rsp_valid", 512'(rsp_valid), 512'(0));
    checkOutput("rst_mem_req", 512'(mem_req), 512'(0));
    checkOutput("rst_fill_valid", 512'(fill_valid), 512'(0));
    checkOutput("rst_mem_addr", 512'(mem_addr), 512'(0));
    checkOutput("rst_lru_set0", 512'(dut.u_lru.order_q[0]), 512'(ORDER_IDENTITY));
    reset = 1'b0;
    #1;
    checkOutput("idle_req_ready", 512'(req_ready), 512'(1));

    // Hit on set 0, way 5: tag 1, block 1, response two edges after accept
    applyStimulus(32'h0000_0840, 1'b1, 3'd5, LINE_HIT_A);
    tick();
    req_valid = 1'b0;
    checkOutput("hit_lk_valid", 512'(lk_valid), 512'(1));
    checkOutput("hit_lk_tag", 512'(lk_tag), 512'(1));
    checkOutput("hit_lk_index", 512'(lk_index), 512'(0));
    checkOutput("hit_lk_block", 512'(lk_block), 512'(1));
    checkOutput("hit_rsp_early", 512'(rsp_valid), 512'(0));
    checkOutput("hit_req_ready_busy", 512'(req_ready), 512'(0));
    tick();
    checkOutput("hit_rsp_valid", 512'(rsp_valid), 512'(1));
    checkOutput("hit_rsp_hit", 512'(rsp_hit), 512'(1));
    checkOutput("hit_rsp_data", rsp_data, LINE_HIT_A);
    checkOutput("hit_lru_set0", 512'(dut.u_lru.order_q[0]), 512'(24'o76432105));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    lk_done   = 1'b0;
    checkOutput("hit_back_idle", 512'(req_ready), 512'(1));

    // Quarter-compressible miss after a fresh reset: LRU victim way 7
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(32'h0000_1265, 1'b0, 3'd0, LINE_QUART);
    mem_ack          = 1'b1;
    alloc_done       = 1'b1;
    alloc_cand_valid = 1'b0;
    fill_ack         = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    checkOutput("q_mem_req", 512'(mem_req), 512'(1));
    checkOutput("q_mem_addr", 512'(mem_addr), 512'(32'h0000_1240));
    tick();
    checkOutput("q_alloc_valid", 512'(alloc_valid), 512'(1));
    checkOutput("q_alloc_cf", 512'(alloc_cf), 512'(2'b10));
    tick();
    checkOutput("q_fill_valid", 512'(fill_valid), 512'(1));
    checkOutput("q_fill_way", 512'(fill_way), 512'(7));
    checkOutput("q_fill_merge", 512'(fill_merge), 512'(0));
    checkOutput("q_fill_data", fill_data, LINE_QUART);
    checkOutput("q_rsp_early", 512'(rsp_valid), 512'(0));
    fill_ack = 1'b1;
    tick();
    checkOutput("q_rsp_valid", 512'(rsp_valid), 512'(1));
    checkOutput("q_rsp_hit", 512'(rsp_hit), 512'(0));
    checkOutput("q_rsp_data", rsp_data, LINE_QUART);
    checkOutput("q_lru_set2", 512'(dut.u_lru.order_q[2]), 512'(24'o65432107));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Half-compressible miss merging into candidate way 4, five edges total
    applyStimulus(32'h0000_0340, 1'b0, 3'd0, LINE_HALF);
    alloc_cand_valid = 1'b1;
    alloc_cand_way   = 3'd4;
    alloc_cand_merge = 1'b1;
    fill_ack         = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checkOutput("h_alloc_cf", 512'(alloc_cf), 512'(2'b01));
    tick();
    checkOutput("h_fill_way", 512'(fill_way), 512'(4));
    checkOutput("h_fill_merge", 512'(fill_merge), 512'(1));
    checkOutput("h_fill_cf", 512'(fill_cf), 512'(2'b01));
    checkOutput("h_rsp_early", 512'(rsp_valid), 512'(0));
    tick();
    checkOutput("h_rsp_valid", 512'(rsp_valid), 512'(1));
    checkOutput("h_rsp_hit", 512'(rsp_hit), 512'(0));
    checkOutput("h_lru_set3", 512'(dut.u_lru.order_q[3]), 512'(24'o76532104));
    rsp_ready = 1'b1;
    tick();
    rsp_ready        = 1'b0;
    alloc_cand_valid = 1'b0;
    alloc_cand_merge = 1'b0;

    // Slow lookup, memory and response; uncompressed line picks way 3 of set 5
    applyStimulus(32'h0000_0500, 1'b0, 3'd0, LINE_FULL);
    lk_done    = 1'b0;
    mem_ack    = 1'b0;
    alloc_done = 1'b0;
    fill_ack   = 1'b0;
    tick();
    req_valid = 1'b0;
    checkOutput("s_lk_valid_first", 512'(lk_valid), 512'(1));
    tick();
    checkOutput("s_lk_valid_once", 512'(lk_valid), 512'(0));
    lk_done = 1'b1;
    tick();
    lk_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("s_mem_req_held", 512'(mem_req), 512'(1));
      checkOutput("s_req_ready_mem", 512'(req_ready), 512'(0));
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("s_mem_req_drop", 512'(mem_req), 512'(0));
    checkOutput("s_alloc_valid_first", 512'(alloc_valid), 512'(1));
    checkOutput("s_alloc_cf", 512'(alloc_cf), 512'(2'b00));
    tick();
    checkOutput("s_alloc_valid_once", 512'(alloc_valid), 512'(0));
    alloc_done = 1'b1;
    tick();
    alloc_done = 1'b0;
    checkOutput("s_fill_way", 512'(fill_way), 512'(3));
    checkOutput("s_fill_merge", 512'(fill_merge), 512'(0));
    checkOutput("s_fill_data", fill_data, LINE_FULL);
    fill_ack = 1'b1;
    tick();
    fill_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("s_rsp_valid_held", 512'(rsp_valid), 512'(1));
      checkOutput("s_rsp_data_stable", rsp_data, LINE_FULL);
      checkOutput("s_req_ready_resp", 512'(req_ready), 512'(0));
      tick();
    end
    checkOutput("s_lru_set5", 512'(dut.u_lru.order_q[5]), 512'(24'o76542103));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("s_rsp_done", 512'(rsp_valid), 512'(0));
    checkOutput("s_req_ready_idle", 512'(req_ready), 512'(1));

    // Reset while a fill is pending
    applyStimulus(32'h0000_0640, 1'b0, 3'd0, LINE_QUART);
    mem_ack    = 1'b1;
    alloc_done = 1'b1;
    fill_ack   = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("r_fill_valid_pre", 512'(fill_valid), 512'(1));
    checkOutput("r_fill_way_pre", 512'(fill_way), 512'(7));
    reset = 1'b1;
    #1;
    checkOutput("r_fill_valid", 512'(fill_valid), 512'(0));
    checkOutput("r_fill_way", 512'(fill_way), 512'(0));
    checkOutput("r_mem_req", 512'(mem_req), 512'(0));
    checkOutput("r_req_ready", 512'(req_ready), 512'(0));
    checkOutput("r_fill_data", fill_data, 512'(0));
    checkOutput("r_lru_set3", 512'(dut.u_lru.order_q[3]), 512'(ORDER_IDENTITY));
    checkOutput("r_lru_set5", 512'(dut.u_lru.order_q[5]), 512'(ORDER_IDENTITY));
    checkOutput("r_lru_set6", 512'(dut.u_lru.order_q[6]), 512'(ORDER_IDENTITY));
    #2;
    reset = 1'b0;
    tick();
    runTransaction(32'h0000_0100, 1'b1, 3'd2, LINE_HIT_B);
    checkOutput("r_lru_set1", 512'(dut.u_lru.order_q[1]), 512'(24'o76543102));

    // Statistics: three hits and two misses since the last reset
    runTransaction(32'h0000_0200, 1'b1, 3'd1, LINE_HIT_A);
    runTransaction(32'h0000_0300, 1'b1, 3'd6, LINE_HIT_B);
    runTransaction(32'h0000_0400, 1'b0, 3'd0, LINE_FULL);
    runTransaction(32'h0000_0700, 1'b0, 3'd0, LINE_HALF);
`ifdef YACC_STATS_EN
    checkOutput("st_hit_count", 512'(hit_count), 512'(3));
    checkOutput("st_miss_count", 512'(miss_count), 512'(2));
`else
    checkOutput("st_hit_count", 512'(hit_count), 512'(0));
    checkOutput("st_miss_count", 512'(miss_count), 512'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
